quad_encoder_counter: RTL and testbench

//  Parametrised rotary/quadrature encoder front end, successor to the fixed PmodENC

---
 rtl/qenc_pkg.sv | 33 +++
 rtl/qenc_debounce.sv | 36 +++
 rtl/quad_encoder_counter.sv | 111 +++++++++++
 tb/tb_quad_encoder_counter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/qenc_pkg.sv
// rtl/qenc_pkg.sv - shared encodings and quadrature transition table for the encoder counter
package qenc_pkg;

    localparam int DECODE_X1 = 1;
    localparam int DECODE_X2 = 2;
    localparam int DECODE_X4 = 4;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef struct packed {
        logic valid;
        logic cw;
        logic illegal;
    } qenc_step_t;

    // {A,B} is mapped to its position on the CW cycle 00->10->11->01, so the
    // position delta classifies the move: +1 CW, -1 CCW, 2 both bits flipped.
    function automatic qenc_step_t qenc_dir(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] p_pos;
        logic [1:0] c_pos;
        logic [1:0] delta;
        qenc_step_t s;
        p_pos     = {prev[0], prev[1] ^ prev[0]};
        c_pos     = {cur[0], cur[1] ^ cur[0]};
        delta     = c_pos - p_pos;
        s.valid   = (delta == 2'd1) || (delta == 2'd3);
        s.cw      = (delta == 2'd1);
        s.illegal = (delta == 2'd2);
        return s;
    endfunction

endpackage

// File: rtl/qenc_debounce.sv
// rtl/qenc_debounce.sv - two-flop synchroniser followed by a stability-window debouncer
module qenc_debounce #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    localparam int CNT_BITS = $clog2(DB_CYCLES);

    logic [1:0]          sync;
    logic [CNT_BITS-1:0] win_cnt;

    // The window counts consecutive clocks where the synced level disagrees
    // with the output; any agreement restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= 2'b00;
            win_cnt <= '0;
            clean   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == clean) begin
                win_cnt <= '0;
            end else if (win_cnt == CNT_BITS'(DB_CYCLES - 1)) begin
                clean   <= sync[1];
                win_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/quad_encoder_counter.sv
// rtl/quad_encoder_counter.sv - debounced quadrature decoder with bounded wrap/saturate position count
module quad_encoder_counter
    import qenc_pkg::*;
#(
    parameter int CNT_W     = 5,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 19,
    parameter int DECODE_X  = 1,
    parameter int WRAP      = 1,
    parameter int DB_CYCLES = 1000
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_btn,
    input  logic             clear,
    output logic [CNT_W-1:0] count_out,
    output logic             dir,
    output logic             step_pulse,
    output logic             at_limit,
    output logic             err_pulse
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_VAL);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);

    logic             db_a;
    logic             db_b;
    logic             db_btn;
    logic             btn_prev;
    logic [1:0]       prev_ab;
    logic [1:0]       dec_cur;
    qenc_step_t       dec_step;
    logic             counts;
    logic             do_clear;
    logic [CNT_W-1:0] next_count;

    qenc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
        .clk(clk_100MHz), .reset(reset), .raw(enc_a), .clean(db_a)
    );
    qenc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
        .clk(clk_100MHz), .reset(reset), .raw(enc_b), .clean(db_b)
    );
    qenc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_btn (
        .clk(clk_100MHz), .reset(reset), .raw(enc_btn), .clean(db_btn)
    );

    // Decode stage: classify prev->current and keep the destination state so
    // the x1/x2 filters can look at where the transition landed.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            prev_ab  <= 2'b00;
            dec_cur  <= 2'b00;
            dec_step <= '0;
            btn_prev <= 1'b0;
        end else begin
            prev_ab  <= {db_a, db_b};
            dec_cur  <= {db_a, db_b};
            dec_step <= qenc_dir(prev_ab, {db_a, db_b});
            btn_prev <= db_btn;
        end
    end

    always_comb begin
        counts = 1'b0;
        case (DECODE_X)
            DECODE_X4: counts = dec_step.valid;
            DECODE_X2: counts = dec_step.valid && ((dec_cur == 2'b00) || (dec_cur == 2'b11));
            default:   counts = dec_step.valid && (dec_cur == 2'b00);
        endcase
    end

    assign do_clear = clear || (db_btn && !btn_prev);

    always_comb begin
        next_count = count_out;
        if (counts) begin
            if (dec_step.cw) begin
                if (count_out == MAX_C) next_count = (WRAP != 0) ? MIN_C : MAX_C;
                else                    next_count = count_out + CNT_W'(1);
            end else begin
                if (count_out == MIN_C) next_count = (WRAP != 0) ? MAX_C : MIN_C;
                else                    next_count = count_out - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            count_out  <= MIN_C;
            dir        <= DIR_CW;
            step_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            at_limit   <= (WRAP == 0);
        end else begin
            err_pulse <= dec_step.illegal;
            if (dec_step.valid) dir <= dec_step.cw ? DIR_CW : DIR_CCW;
            if (do_clear) begin
                count_out  <= MIN_C;
                step_pulse <= 1'b0;
                at_limit   <= (WRAP == 0);
            end else begin
                count_out  <= next_count;
                step_pulse <= (next_count != count_out);
                at_limit   <= (WRAP == 0) && ((next_count == MIN_C) || (next_count == MAX_C));
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// tb/tb_quad_encoder_counter.sv - directed vector bench for quad_encoder_counter in x4/x1 wrap and saturate builds
module tb_quad_encoder_counter;

    localparam int DB = 4;

    typedef struct {
        logic [1:0] ab;
        int btn;
        int c4, c1, cs;
        int d, ats;
        int s4, s1, ss, e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enc_a = 1'b0, enc_b = 1'b0, enc_btn = 1'b0, clear = 1'b0;
    logic [4:0] cnt4, cnt1, cnts;
    logic dir4, dir1, dirs, stp4, stp1, stps, at4, at1, ats, err4, err1, errs;

    int n_vec = 0;
    int n_fail = 0;
    int p4 = 0, p1 = 0, ps = 0, pe = 0;
    vec_t tbl[44];
    logic [1:0] pos_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always #5 clk = ~clk;

    quad_encoder_counter #(.CNT_W(5), .MIN_VAL(0), .MAX_VAL(19), .DECODE_X(4), .WRAP(1), .DB_CYCLES(DB)) u_x4 (
        .clk_100MHz(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn), .clear(clear),
        .count_out(cnt4), .dir(dir4), .step_pulse(stp4), .at_limit(at4), .err_pulse(err4)
    );
    quad_encoder_counter #(.CNT_W(5), .MIN_VAL(0), .MAX_VAL(19), .DECODE_X(1), .WRAP(1), .DB_CYCLES(DB)) u_x1 (
        .clk_100MHz(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn), .clear(clear),
        .count_out(cnt1), .dir(dir1), .step_pulse(stp1), .at_limit(at1), .err_pulse(err1)
    );
    quad_encoder_counter #(.CNT_W(5), .MIN_VAL(0), .MAX_VAL(19), .DECODE_X(4), .WRAP(0), .DB_CYCLES(DB)) u_sat (
        .clk_100MHz(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn), .clear(clear),
        .count_out(cnts), .dir(dirs), .step_pulse(stps), .at_limit(ats), .err_pulse(errs)
    );

    always @(negedge clk) begin
        p4 = p4 + int'(stp4);
        p1 = p1 + int'(stp1);
        ps = ps + int'(stps);
        pe = pe + int'(err4);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic zero_pulses();
        p4 = 0; p1 = 0; ps = 0; pe = 0;
    endtask

    function automatic vec_t mk(input logic [1:0] ab, input int btn, input int c4, input int c1, input int cs,
                                input int d, input int at, input int s4, input int s1, input int ss, input int e);
        vec_t v;
        v.ab = ab; v.btn = btn; v.c4 = c4; v.c1 = c1; v.cs = cs;
        v.d = d; v.ats = at; v.s4 = s4; v.s1 = s1; v.ss = ss; v.e = e;
        return v;
    endfunction

    task automatic run_vec(input int idx);
        vec_t v;
        v = tbl[idx];
        @(posedge clk); #1;
        {enc_a, enc_b} = v.ab;
        enc_btn = (v.btn != 0);
        zero_pulses();
        repeat (DB + 6) @(posedge clk);
        #2;
        chk($sformatf("v%0d count_x4", idx), int'(cnt4), v.c4);
        chk($sformatf("v%0d count_x1", idx), int'(cnt1), v.c1);
        chk($sformatf("v%0d count_sat", idx), int'(cnts), v.cs);
        chk($sformatf("v%0d dir", idx), int'(dir4), v.d);
        chk($sformatf("v%0d at_limit_sat", idx), int'(ats), v.ats);
        chk($sformatf("v%0d steps_x4", idx), p4, v.s4);
        chk($sformatf("v%0d steps_x1", idx), p1, v.s1);
        chk($sformatf("v%0d steps_sat", idx), ps, v.ss);
        chk($sformatf("v%0d errs", idx), pe, v.e);
    endtask

    initial begin
        // ab, btn, x4, x1, sat, dir, sat_at_limit, x4/x1/sat step pulses, err pulses
        tbl[0]  = mk(2'b11, 0,  2,  0, 2, 1, 0, 1, 0, 1, 0);
        tbl[1]  = mk(2'b01, 0,  3,  0, 3, 1, 0, 1, 0, 1, 0);
        tbl[2]  = mk(2'b00, 0,  4,  1, 4, 1, 0, 1, 1, 1, 0);
        tbl[3]  = mk(2'b01, 0,  3,  1, 3, 0, 0, 1, 0, 1, 0);
        tbl[4]  = mk(2'b11, 0,  2,  1, 2, 0, 0, 1, 0, 1, 0);
        tbl[5]  = mk(2'b10, 0,  1,  1, 1, 0, 0, 1, 0, 1, 0);
        tbl[6]  = mk(2'b00, 0,  0,  0, 0, 0, 1, 1, 1, 1, 0);
        tbl[7]  = mk(2'b01, 0, 19,  0, 0, 0, 1, 1, 0, 0, 0);
        tbl[8]  = mk(2'b11, 0, 18,  0, 0, 0, 1, 1, 0, 0, 0);
        tbl[9]  = mk(2'b10, 0, 17,  0, 0, 0, 1, 1, 0, 0, 0);
        tbl[10] = mk(2'b00, 0, 16, 19, 0, 0, 1, 1, 1, 0, 0);
        tbl[11] = mk(2'b10, 0, 17, 19, 1, 1, 0, 1, 0, 1, 0);
        tbl[12] = mk(2'b11, 0, 18, 19, 2, 1, 0, 1, 0, 1, 0);
        tbl[13] = mk(2'b01, 0, 19, 19, 3, 1, 0, 1, 0, 1, 0);
        tbl[14] = mk(2'b00, 0,  0,  0, 4, 1, 0, 1, 1, 1, 0);
        for (int j = 1; j <= 15; j++)
            tbl[14 + j] = mk(pos_seq[j % 4], 0, j, j / 4, 4 + j, 1, int'(j == 15), 1, int'(j % 4 == 0), 1, 0);
        tbl[30] = mk(2'b00, 0, 16,  4, 19, 1, 1, 1, 1, 0, 0);
        tbl[31] = mk(2'b10, 0, 17,  4, 19, 1, 1, 1, 0, 0, 0);
        tbl[32] = mk(2'b00, 0, 16,  3, 18, 0, 0, 1, 1, 1, 0);
        tbl[33] = mk(2'b11, 0, 16,  3, 18, 0, 0, 0, 0, 0, 1);
        tbl[34] = mk(2'b00, 0, 16,  3, 18, 0, 0, 0, 0, 0, 1);
        tbl[35] = mk(2'b00, 1,  0,  0,  0, 0, 1, 0, 0, 0, 0);
        tbl[36] = mk(2'b00, 0,  0,  0,  0, 0, 1, 0, 0, 0, 0);
        tbl[37] = mk(2'b11, 0,  2,  0,  2, 1, 0, 1, 0, 1, 0);
        tbl[38] = mk(2'b01, 0,  3,  0,  3, 1, 0, 1, 0, 1, 0);
        tbl[39] = mk(2'b00, 0,  4,  1,  4, 1, 0, 1, 1, 1, 0);
        tbl[40] = mk(2'b10, 0,  5,  1,  5, 1, 0, 1, 0, 1, 0);
        tbl[41] = mk(2'b11, 0,  6,  1,  6, 1, 0, 1, 0, 1, 0);
        tbl[42] = mk(2'b01, 0,  7,  1,  7, 1, 0, 1, 0, 1, 0);
        tbl[43] = mk(2'b01, 0, 19,  0,  0, 0, 1, 1, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("reset count_x4", int'(cnt4), 0);
        chk("reset count_x1", int'(cnt1), 0);
        chk("reset count_sat", int'(cnts), 0);
        chk("reset dir", int'(dir4 & dir1 & dirs), 1);
        chk("reset pulses", int'(stp4 | stp1 | stps | err4 | err1 | errs), 0);
        chk("reset at_limit_sat", int'(ats), 1);
        chk("reset at_limit_wrap", int'(at4 | at1), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // First CW edge: step lands exactly DB+4 clocks after the raw edge.
        @(posedge clk); #1;
        enc_a = 1'b1;
        zero_pulses();
        repeat (DB + 3) @(posedge clk);
        #2;
        chk("latency early step", int'(stp4), 0);
        chk("latency early count", int'(cnt4), 0);
        @(posedge clk); #2;
        chk("latency step_x4", int'(stp4), 1);
        chk("latency step_x1", int'(stp1), 0);
        chk("latency count_x4", int'(cnt4), 1);
        chk("latency dir", int'(dir4), 1);

        for (int i = 0; i <= 36; i++) run_vec(i);

        // A chatters every 2 clocks, shorter than the window, then settles high.
        @(posedge clk); #1;
        zero_pulses();
        for (int i = 0; i < 10; i++) begin
            enc_a = ~enc_a;
            repeat (2) @(posedge clk);
            #1;
        end
        enc_a = 1'b1;
        repeat (DB + 6) @(posedge clk);
        #2;
        chk("bounce count_x4", int'(cnt4), 1);
        chk("bounce count_sat", int'(cnts), 1);
        chk("bounce steps_x4", p4, 1);
        chk("bounce errs", pe, 0);

        for (int i = 37; i <= 42; i++) run_vec(i);

        // clear lands on the same clock as a counting CW step at count 7.
        @(posedge clk); #1;
        enc_b = 1'b0;
        zero_pulses();
        repeat (DB + 3) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        #1;
        chk("clear count_x4", int'(cnt4), 0);
        chk("clear count_x1", int'(cnt1), 0);
        chk("clear count_sat", int'(cnts), 0);
        repeat (4) @(posedge clk);
        #2;
        chk("clear hold count_x4", int'(cnt4), 0);
        chk("clear steps", p4 + p1 + ps, 0);
        chk("clear at_limit_sat", int'(ats), 1);

        run_vec(43);

        // Button press and rotation in flight, then a reset pulse.
        @(posedge clk); #1;
        enc_a = 1'b1;
        enc_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        enc_btn = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midreset count_x4", int'(cnt4), 0);
        chk("midreset dir", int'(dir4), 1);
        chk("midreset at_limit_sat", int'(ats), 1);
        chk("midreset pulses", int'(stp4 | err4), 0);
        zero_pulses();
        repeat (DB + 6) @(posedge clk);
        #2;
        chk("midreset settle count_x4", int'(cnt4), 0);
        chk("midreset settle pulses", p4 + pe, 0);

        // Pins resting at 11 across reset decode once as an illegal 00->11.
        @(posedge clk); #1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        zero_pulses();
        repeat (DB + 8) @(posedge clk);
        #2;
        chk("rest11 errs", pe, 1);
        chk("rest11 count_x4", int'(cnt4), 0);
        chk("rest11 steps", p4, 0);
        chk("rest11 dir", int'(dir4), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
